// File: rtl/wb_arb_pkg.sv
// Shared types and width helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  // Arbiter top-level state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // Width of an owner/last index for n masters (at least one bit).
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the outstanding-transfer counter; must hold max_outst itself.
  function automatic int outst_w(input int max_outst);
    return (max_outst > 1) ? $clog2(max_outst + 1) : 1;
  endfunction

  // Width of the watchdog counter; must hold timeout itself.
  function automatic int wdog_w(input int timeout);
    return (timeout > 1) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Rotating priority encoder: picks the first requester after 'last'.
// Kept standalone so the interrupt mux can reuse it.
module rr_pick #(
  parameter int N  = 3,
  parameter int OW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [OW-1:0] last_i,
  output logic [OW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  // Scan from the lowest priority (last itself) to the highest (last+1) so the
  // final write wins and no priority chain has to be built explicitly.
  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req_i[(int'(last_i) + i) % N]) begin
        gnt_idx_o   = OW'((int'(last_i) + i) % N);
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone B4 slave between N
// masters. The grant is held for the owner's whole cyc; a watchdog
// error-completes transfers a hung slave never answers.
//
//   state | meaning
//   IDLE  | no owner, slave idle, waiting for any m_cyc
//   BUSY  | owner routed to the slave, counting outstanding transfers
//   DRAIN | watchdog fired, slave aborted, erroring out outstanding transfers
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N         = 3,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 255,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      m_cyc,
  input  logic [N-1:0]      m_stb,
  input  logic [N-1:0]      m_we,
  input  logic [N*DW/8-1:0] m_sel,
  input  logic [N*AW-1:0]   m_adr,
  input  logic [N*DW-1:0]   m_dat_w,
  output logic [N*DW-1:0]   m_dat_r,
  output logic [N-1:0]      m_ack,
  output logic [N-1:0]      m_err,
  output logic [N-1:0]      m_stall,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [DW/8-1:0]   s_sel,
  output logic [AW-1:0]     s_adr,
  output logic [DW-1:0]     s_dat_w,
  input  logic [DW-1:0]     s_dat_r,
  input  logic              s_ack,
  input  logic              s_err,
  input  logic              s_stall,
  output logic              timeout_o
);

  localparam int SW = DW / 8;
  localparam int OW = owner_w(N);
  localparam int CW = outst_w(MAX_OUTST);
  localparam int WW = wdog_w(TIMEOUT);

  localparam logic [OW-1:0] LAST_RST  = OW'(N - 1);
  localparam logic [CW-1:0] OUTST_MAX = CW'(MAX_OUTST);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q,  last_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [WW-1:0] wdog_q,  wdog_d;

  logic [OW-1:0] pick_idx;
  logic          pick_valid;

  logic own_cyc;
  logic own_stb;
  logic full;
  logic has_outst;
  logic accept;
  logic complete;
  logic wdog_fire;

  rr_pick #(
    .N  (N),
    .OW (OW)
  ) u_pick (
    .req_i       (m_cyc),
    .last_i      (last_q),
    .gnt_idx_o   (pick_idx),
    .gnt_valid_o (pick_valid)
  );

  // Owner-side handshake terms; only meaningful while BUSY.
  always_comb begin
    own_cyc   = m_cyc[owner_q];
    own_stb   = m_stb[owner_q];
    full      = (outst_q == OUTST_MAX);
    has_outst = (outst_q != '0);
    accept    = (state_q == BUSY) && own_cyc && own_stb && !full && !s_stall;
    // A completion with nothing outstanding is a stray and is dropped.
    complete  = (state_q == BUSY) && own_cyc && (s_ack || s_err) && has_outst;
  end

  // Watchdog trip: outstanding work, no slave progress, budget exhausted.
  always_comb begin
    wdog_fire = (state_q == BUSY) && own_cyc && has_outst && !accept &&
                !complete && (wdog_q == WDOG_LAST);
  end

  // Slave-side and master-side routing from the registered owner.
  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_sel     = '0;
    s_adr     = '0;
    s_dat_w   = '0;
    m_ack     = '0;
    m_err     = '0;
    m_stall   = '1;
    m_dat_r   = {N{s_dat_r}};
    timeout_o = wdog_fire;
    case (state_q)
      BUSY: begin
        s_cyc   = own_cyc;
        // Hold the strobe back from the slave when the pipe is full; the
        // master sees stall, so the slave must not see a request either.
        s_stb   = own_cyc && own_stb && !full;
        s_we    = m_we[owner_q];
        s_sel   = m_sel[owner_q*SW +: SW];
        s_adr   = m_adr[owner_q*AW +: AW];
        s_dat_w = m_dat_w[owner_q*DW +: DW];
        m_stall[owner_q] = s_stall || full;
        m_ack[owner_q]   = s_ack && has_outst;
        m_err[owner_q]   = s_err && has_outst;
      end
      DRAIN: begin
        m_err[owner_q] = has_outst;
      end
      default: ;
    endcase
  end

  // Next-state, grant and counter update.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    outst_d = outst_q;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        outst_d = '0;
        wdog_d  = '0;
        if (pick_valid) begin
          state_d = BUSY;
          owner_d = pick_idx;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          // Master abort: whatever is still in flight is forgotten.
          state_d = IDLE;
          last_d  = owner_q;
          outst_d = '0;
          wdog_d  = '0;
        end else begin
          if (accept && !complete) begin
            outst_d = outst_q + CW'(1);
          end else if (complete && !accept) begin
            outst_d = outst_q - CW'(1);
          end
          // Any slave progress restarts the watchdog window.
          if (!has_outst || accept || complete) begin
            wdog_d = '0;
          end else if (wdog_fire) begin
            wdog_d  = '0;
            state_d = DRAIN;
          end else begin
            wdog_d = wdog_q + WW'(1);
          end
        end
      end
      DRAIN: begin
        wdog_d = '0;
        if (outst_q <= CW'(1)) begin
          state_d = IDLE;
          last_d  = owner_q;
          outst_d = '0;
        end else begin
          outst_d = outst_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops s_cyc immediately through the routing logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      outst_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      outst_q <= outst_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with bench-side master/slave models and a
// per-master scoreboard of expected responses.
module tb_wb_rr_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 255;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
  logic [N*SW-1:0] m_sel = '1;
  logic [N*AW-1:0] m_adr = '0;
  logic [N*DW-1:0] m_dat_w = '0;
  logic [N*DW-1:0] m_dat_r;
  logic [N-1:0]    m_ack, m_err, m_stall;
  logic            s_cyc, s_stb, s_we;
  logic [SW-1:0]   s_sel;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w;
  logic [DW-1:0]   s_dat_r = '0;
  logic            s_ack = 1'b0, s_err = 1'b0, s_stall = 1'b0;
  logic            timeout_o;

  wb_rr_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TO), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr),
    .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .m_stall(m_stall), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack),
    .s_err(s_err), .s_stall(s_stall), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } op_t;

  op_t         opq [N][$];
  op_t         expq[N][$];
  int          mo[N];
  bit          hold[N];
  int          errs[N];
  int          first_cyc[N], first_acc[N];
  bit          stall_seen[N];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] pend[$];
  int          glog[$];
  bit          slv_en = 1'b1, force_ack = 1'b0, force_err = 1'b0;
  bit          s_cyc_prev = 1'b0, viol = 1'b0;
  int          cyc_n = 0, last_acc = 0, to_cyc = 0, to_cnt = 0, err_scyc = 0;
  int          n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic q_op(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    op_t o;
    o.we = we; o.adr = adr; o.dat = dat;
    opq[m].push_back(o);
  endtask

  function automatic bit busy();
    for (int m = 0; m < N; m++)
      if (opq[m].size() > 0 || mo[m] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_tb();
    for (int m = 0; m < N; m++) begin
      opq[m].delete(); expq[m].delete();
      mo[m] = 0; hold[m] = 1'b0; errs[m] = 0;
      first_cyc[m] = -1; first_acc[m] = -1; stall_seen[m] = 1'b0;
    end
    pend.delete(); glog.delete();
    m_cyc = '0; m_stb = '0; m_we = '0;
    s_cyc_prev = 1'b0; viol = 1'b0; to_cnt = 0; err_scyc = 0;
  endtask

  // One bus cycle: drive at negedge, sample 1ns later, models react.
  task automatic step();
    int own;
    @(negedge clk);
    cyc_n++;
    s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;
    if (force_ack) s_ack = 1'b1;
    else if (force_err) s_err = 1'b1;
    else if (slv_en && pend.size() > 0) begin
      s_ack = 1'b1; s_dat_r = pend.pop_front();
    end
    force_ack = 1'b0; force_err = 1'b0;
    for (int m = 0; m < N; m++) begin
      logic c;
      c = (opq[m].size() > 0) || (mo[m] > 0) || hold[m];
      if (c && !m_cyc[m]) first_cyc[m] = cyc_n;
      m_cyc[m] = c;
      m_stb[m] = c && (opq[m].size() > 0);
      if (m_stb[m]) begin
        m_we[m] = opq[m][0].we;
        m_adr[m*AW +: AW] = opq[m][0].adr;
        m_dat_w[m*DW +: DW] = opq[m][0].dat;
      end else begin
        m_we[m] = 1'b0;
      end
    end
    #1;
    if (timeout_o) begin to_cnt++; to_cyc = cyc_n; end
    if (s_cyc && !s_cyc_prev) begin
      own = -1;
      for (int m = 0; m < N; m++) if (m_cyc[m] && !m_stall[m]) own = m;
      glog.push_back(own);
    end
    for (int m = 0; m < N; m++) begin
      if (!m_stall[m]) stall_seen[m] = 1'b1;
      if (m == 2 && !m_stall[2] && m_cyc[0]) viol = 1'b1;
      if (m_ack[m] || m_err[m]) begin
        check("resp_expected", 64'(expq[m].size() > 0), 64'd1);
        if (expq[m].size() > 0) begin
          op_t e;
          e = expq[m].pop_front();
          if (m_ack[m] && !e.we) check("rdata", 64'(m_dat_r[m*DW +: DW]), 64'(e.dat));
        end
        if (m_err[m]) begin errs[m]++; if (s_cyc) err_scyc++; end
        if (mo[m] > 0) mo[m]--;
      end
      if (m_cyc[m] && m_stb[m] && !m_stall[m]) begin
        op_t o;
        o = opq[m].pop_front();
        expq[m].push_back(o);
        mo[m]++;
        if (first_acc[m] < 0) first_acc[m] = cyc_n;
        last_acc = cyc_n;
      end
    end
    if (s_cyc && s_stb && !s_stall) begin
      if (s_we) begin mem[s_adr] = s_dat_w; pend.push_back(32'h0); end
      else pend.push_back(mem.exists(s_adr) ? mem[s_adr] : 32'h0);
    end
    if (!s_cyc) pend.delete();
    s_cyc_prev = s_cyc;
  endtask

  task automatic run_done(input string tag, input int max);
    int k;
    k = 0;
    while (k < max && busy()) begin step(); k++; end
    check({tag, "_done"}, 64'(busy()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_tb();
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    clear_tb();
    // Reset with every master requesting: nothing may be granted.
    for (int m = 0; m < N; m++) hold[m] = 1'b1;
    step();
    check("rst_s_cyc", 64'(s_cyc), 64'd0);
    check("rst_s_stb", 64'(s_stb), 64'd0);
    check("rst_m_stall", 64'(m_stall), 64'h7);
    check("rst_m_ack", 64'(m_ack), 64'd0);
    check("rst_m_err", 64'(m_err), 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    clear_tb();
    step();
    rst_n = 1'b1;

    // Single master 1: write then read 0x3000.
    q_op(1, 1'b1, 32'h3000, 32'h1234_5678);
    q_op(1, 1'b0, 32'h3000, 32'h1234_5678);
    run_done("t1", 40);
    check("t1_grant_lat", 64'(first_acc[1] - first_cyc[1]), 64'd1);
    check("t1_m0_stalled", 64'(stall_seen[0]), 64'd0);
    check("t1_m2_stalled", 64'(stall_seen[2]), 64'd0);
    step(); step();

    // Three simultaneous requesters right after reset: order 0,1,2.
    do_reset();
    for (int m = 0; m < N; m++) q_op(m, 1'b1, 32'h100 + 32'(m), 32'hA0 + 32'(m));
    run_done("t2", 60);
    step(); step();
    check("t2_grants", 64'(glog.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < glog.size()) check("t2_order", 64'(glog[i]), 64'(i));

    // Master 0 burst of three reads; master 2 arrives mid-burst.
    glog.delete(); viol = 1'b0;
    for (int i = 0; i < 3; i++) q_op(0, 1'b0, 32'h100 + 32'(i), 32'hA0 + 32'(i));
    step(); step();
    q_op(2, 1'b1, 32'h200, 32'h5555_AAAA);
    run_done("t3", 60);
    step(); step();
    check("t3_m2_held_off", 64'(viol), 64'd0);
    check("t3_grants", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) begin
      check("t3_first", 64'(glog[0]), 64'd0);
      check("t3_second", 64'(glog[1]), 64'd2);
    end

    // Hung slave with two reads outstanding on master 1.
    slv_en = 1'b0; to_cnt = 0; err_scyc = 0; errs[1] = 0;
    q_op(1, 1'b0, 32'h3000, 32'h0);
    q_op(1, 1'b0, 32'h3004, 32'h0);
    k = 0;
    while (k < 400 && (to_cnt == 0 || busy())) begin step(); k++; end
    check("t4_finished", 64'(k < 400), 64'd1);
    check("t4_pulses", 64'(to_cnt), 64'd1);
    check("t4_delay", 64'(to_cyc - last_acc), 64'd255);
    check("t4_errs", 64'(errs[1]), 64'd2);
    check("t4_err_scyc", 64'(err_scyc), 64'd0);
    step();
    check("t4_idle_scyc", 64'(s_cyc), 64'd0);
    check("t4_idle_stall", 64'(m_stall), 64'h7);
    slv_en = 1'b1;
    step();

    // Reset asserted mid-read, then a clean transfer.
    slv_en = 1'b0; first_acc[0] = -1;
    q_op(0, 1'b0, 32'h3000, 32'h0);
    step(); step(); step();
    check("t5_outstanding", 64'(mo[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_scyc", 64'(s_cyc), 64'd0);
    check("t5_rst_stall", 64'(m_stall), 64'h7);
    clear_tb();
    step(); step();
    rst_n = 1'b1; slv_en = 1'b1;
    q_op(0, 1'b0, 32'h3000, 32'h1234_5678);
    run_done("t5", 40);
    check("t5_no_err", 64'(errs[0]), 64'd0);
    step(); step();

    // Stray ack in IDLE, then an err in BUSY that empties the pipe.
    force_ack = 1'b1;
    step();
    check("t6_idle_ack", 64'(m_ack), 64'd0);
    slv_en = 1'b0; hold[2] = 1'b1; first_acc[2] = -1;
    q_op(2, 1'b0, 32'h3000, 32'h0);
    k = 0;
    while (k < 20 && first_acc[2] < 0) begin step(); k++; end
    check("t6_accepted", 64'(first_acc[2] >= 0), 64'd1);
    step();
    force_err = 1'b1;
    step();
    check("t6_err_fwd", 64'(m_err), 64'h4);
    pend.delete();
    force_ack = 1'b1;
    step();
    check("t6_stray_ack", 64'(m_ack), 64'd0);
    hold[2] = 1'b0; slv_en = 1'b1;
    step(); step();
    check("t6_no_timeout", 64'(to_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
